// File: rtl/code_match_pkg.sv
// Shared types and constants for the code-match sequencer.
// State encoding, code width and the default match bitmap.
package code_match_pkg;

  localparam int CODE_W = 4;

  localparam logic [15:0] DEFAULT_MATCH_SET = 16'h0EC8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/code_match_lut.sv
// Combinational classifier: match = set[code].
// Ports: code (CODE_W), set (16-bit bitmap), match (1).
module code_match_lut
  import code_match_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic [15:0]       set,
  output logic              match
);

  assign match = set[code];

endmodule

// File: rtl/code_match_sequencer.sv
// Code-match sequencer: stream and sweep modes, one-entry output slot,
// saturating hit counter.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_code;
// start_sweep, clear_count; out_valid/out_ready/out_code/out_match;
// hit_count[CNT_W], busy, sweep_done.
// Macro CODE_MATCH_PROG_EN adds cfg_we/cfg_set and a match register.
module code_match_sequencer
  import code_match_pkg::*;
#(
  parameter int          CNT_W     = 8,
  parameter logic [15:0] MATCH_SET = DEFAULT_MATCH_SET
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              start_sweep,
  input  logic              clear_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_match,
  output logic [CNT_W-1:0]  hit_count,
  output logic              busy,
  output logic              sweep_done
`ifdef CODE_MATCH_PROG_EN
  ,
  input  logic              cfg_we,
  input  logic [15:0]       cfg_set
`endif
);

  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE = 1;
  localparam logic [CODE_W-1:0] IDX_MAX = '1;
  localparam logic [CODE_W-1:0] IDX_ONE = 1;

  state_t            state_q;
  state_t            state_d;
  logic [CODE_W-1:0] idx_q;
  logic              slot_free;
  logic              accept;
  logic              load_stream;
  logic              load_sweep;
  logic [CODE_W-1:0] load_code;
  logic              load_match;
  logic [15:0]       match_set;

`ifdef CODE_MATCH_PROG_EN
  // New set takes effect for codes loaded after the write edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      match_set <= MATCH_SET;
    end else if (cfg_we) begin
      match_set <= cfg_set;
    end
  end
`else
  assign match_set = MATCH_SET;
`endif

  assign slot_free = !out_valid || out_ready;
  assign accept    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_sweep) state_d = ST_SWEEP;
      end
      ST_SWEEP: begin
        if (slot_free && idx_q == IDX_MAX)
          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (accept) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // start_sweep masks in_ready so a same-cycle input is not taken.
  always_comb begin
    in_ready    = 1'b0;
    busy        = 1'b0;
    load_stream = 1'b0;
    load_sweep  = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        in_ready    = rst_n && slot_free
                    && !start_sweep;
        load_stream = in_valid && in_ready;
      end
      (state_q == ST_SWEEP): begin
        busy       = 1'b1;
        load_sweep = slot_free;
      end
      (state_q == ST_DRAIN): begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign load_code = load_sweep ? idx_q : in_code;

  code_match_lut u_lut (
    .code  (load_code),
    .set   (match_set),
    .match (load_match)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (state_q == ST_IDLE && start_sweep) begin
      idx_q <= '0;
    end else if (load_sweep) begin
      idx_q <= idx_q + IDX_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_code  <= '0;
      out_match <= 1'b0;
    end else if (load_stream || load_sweep) begin
      out_valid <= 1'b1;
      out_code  <= load_code;
      out_match <= load_match;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= (state_q == ST_DRAIN)
                 && accept;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count <= '0;
    end else if (clear_count) begin
      hit_count <= '0;
    end else if (accept && out_match
              && hit_count != CNT_MAX) begin
      hit_count <= hit_count + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_code_match_sequencer.sv
// Directed bench for code_match_sequencer.
// Runs a CNT_W=8 and a CNT_W=3 instance on shared inputs.
module tb_code_match_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_code;
  logic       start_sweep;
  logic       clear_count;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_code;
  logic       out_match;
  logic [7:0] hit_count;
  logic       busy;
  logic       sweep_done;
  logic       in_ready3;
  logic       out_valid3;
  logic [3:0] out_code3;
  logic       out_match3;
  logic [2:0] hit_count3;
  logic       busy3;
  logic       sweep_done3;
  logic       cfg_we;
  logic [15:0] cfg_set;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  code_match_sequencer #(.CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_code     (in_code),
    .start_sweep (start_sweep),
    .clear_count (clear_count),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_code    (out_code),
    .out_match   (out_match),
    .hit_count   (hit_count),
    .busy        (busy),
    .sweep_done  (sweep_done)
`ifdef CODE_MATCH_PROG_EN
    ,
    .cfg_we      (cfg_we),
    .cfg_set     (cfg_set)
`endif
  );

  code_match_sequencer #(.CNT_W(3)) dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready3),
    .in_code     (in_code),
    .start_sweep (start_sweep),
    .clear_count (clear_count),
    .out_valid   (out_valid3),
    .out_ready   (out_ready),
    .out_code    (out_code3),
    .out_match   (out_match3),
    .hit_count   (hit_count3),
    .busy        (busy3),
    .sweep_done  (sweep_done3)
`ifdef CODE_MATCH_PROG_EN
    ,
    .cfg_we      (cfg_we),
    .cfg_set     (cfg_set)
`endif
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic send(
    input logic [3:0] c,
    input logic       m
  );
    in_valid = 1'b1;
    in_code  = c;
    #1;
    chk("send_rdy", in_ready, 1);
    @(negedge clk);
    chk("send_vld", out_valid, 1);
    chk("send_code", out_code, c);
    chk("send_match", out_match, m);
  endtask

  task automatic run_sweep(
    input bit rnd,
    input int exp_hit
  );
    int  seen;
    bit  ord_ok;
    bit  stab_ok;
    int  dones;
    bit  prev_stall;
    logic [3:0] prev_code;
    logic r;
    seen       = 0;
    ord_ok     = 1'b1;
    stab_ok    = 1'b1;
    dones      = 0;
    prev_stall = 1'b0;
    prev_code  = '0;
    start_sweep = 1'b1;
    in_valid    = rnd;
    in_code     = 4'd5;
    out_ready   = 1'b1;
    #1;
    chk("sw_in_rdy", in_ready, 0);
    @(negedge clk);
    start_sweep = 1'b0;
    in_valid    = 1'b0;
    chk("sw_busy", busy, 1);
    chk("sw_no_acc", out_valid, 0);
    for (int cyc = 0; cyc < 150; cyc++) begin
      if (prev_stall && out_code !== prev_code)
        stab_ok = 1'b0;
      r = rnd ? ($urandom_range(0, 2) != 0)
              : 1'b1;
      out_ready = r;
      if (out_valid && r) begin
        if (seen > 15 || out_code != 4'(seen))
          ord_ok = 1'b0;
        seen++;
      end
      prev_stall = out_valid && !r;
      prev_code  = out_code;
      if (sweep_done) dones++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("sw_count", seen, 16);
    chk("sw_order", ord_ok, 1);
    chk("sw_stable", stab_ok, 1);
    chk("sw_done", dones, 1);
    chk("sw_busy_end", busy, 0);
    chk("sw_hits", hit_count, exp_hit);
    chk("sw_hits_w3", hit_count3, 7);
  endtask

  initial begin
    bit found;
    bit bad;
    rst_n       = 1'b0;
    in_valid    = 1'b1;
    in_code     = 4'd3;
    start_sweep = 1'b0;
    clear_count = 1'b0;
    out_ready   = 1'b1;
    cfg_we      = 1'b0;
    cfg_set     = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_in_rdy", in_ready, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", sweep_done, 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    send(4'd3, 1'b1);
    send(4'd4, 1'b0);
    send(4'd9, 1'b1);
    send(4'd15, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("str_vld", out_valid, 0);
    chk("str_hits", hit_count, 2);

    out_ready = 1'b0;
    send(4'd6, 1'b1);
    in_code = 4'd7;
    #1;
    chk("bp_in_rdy", in_ready, 0);
    @(negedge clk);
    chk("bp_vld", out_valid, 1);
    chk("bp_code", out_code, 6);
    chk("bp_match", out_match, 1);
    out_ready = 1'b1;
    send(4'd7, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_hits", hit_count, 4);

    run_sweep(1'b0, 10);
    run_sweep(1'b1, 16);

    send(4'd10, 1'b1);
    in_valid    = 1'b0;
    clear_count = 1'b1;
    @(negedge clk);
    clear_count = 1'b0;
    chk("clr_hits", hit_count, 0);
    chk("clr_hits_w3", hit_count3, 0);

    start_sweep = 1'b1;
    @(negedge clk);
    start_sweep = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (out_valid && out_code == 4'd7)
        found = 1'b1;
      else
        @(negedge clk);
    end
    chk("mid_reach", found, 1);
    chk("mid_hits_pre", hit_count, 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_busy", busy, 0);
    chk("mid_vld", out_valid, 0);
    chk("mid_hits", hit_count, 0);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sweep_done || out_valid) bad = 1'b1;
    end
    chk("mid_quiet", bad, 0);

`ifdef CODE_MATCH_PROG_EN
    cfg_we  = 1'b1;
    cfg_set = 16'h0001;
    @(negedge clk);
    cfg_we = 1'b0;
    send(4'd0, 1'b1);
    send(4'd3, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed",
             n_pass, n_chk);
    $finish;
  end

endmodule
